// File: rtl/dcache_if.sv
// CPU-side and RAM-side bus of the data cache controller.
// The master view belongs to the controller: it answers the CPU and initiates
// single-word RAM transactions. The slave view is the CPU/RAM environment.
interface dcache_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout, mem_ack,
    output cpu_dout, cpu_stall, mem_cs, mem_we, mem_addr, mem_din
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout, mem_ack,
    input  cpu_dout, cpu_stall, mem_cs, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally; misses evict (if dirty) and refill a 4-word
// line through a word-wide cs/ack RAM, with a cs-low cycle between words.
module dcache_ctrl #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  dcache_if.master   bus,
  output logic [2:0] cache_state
);
  localparam int LINE_WORDS = 4;
  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int TAG_W      = 28 - INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB       = 3'd1,
    WB_GAP   = 3'd2,
    FILL     = 3'd3,
    FILL_GAP = 3'd4
  } state_t;

  logic [LINES-1:0]                 valid, dirty;
  logic [TAG_W-1:0]                 tag_arr  [LINES];
  logic [LINE_WORDS-1:0][31:0]      data_arr [LINES];

  state_t                  state, state_d;
  logic [1:0]              k, k_d, k_nx;
  logic [TAG_W-1:0]        lat_tag;
  logic [INDEX_WIDTH-1:0]  lat_idx;
  logic                    cs_d, we_d;
  logic [31:0]             addr_d, din_d;

  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [1:0]              req_off;
  logic                    hit, idle_hit, miss, ack;
  logic                    unused_addr_bits;

  assign req_tag  = bus.cpu_addr[31:INDEX_WIDTH+4];
  assign req_idx  = bus.cpu_addr[INDEX_WIDTH+3:4];
  assign req_off  = bus.cpu_addr[3:2];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign hit      = bus.cpu_req & valid[req_idx] & (tag_arr[req_idx] == req_tag);
  assign idle_hit = (state == IDLE) & hit;
  assign miss     = (state == IDLE) & bus.cpu_req & ~hit;
  // An ack while cs is low is not ours to consume.
  assign ack      = bus.mem_ack & bus.mem_cs;
  assign k_nx     = k + 2'd1;

  assign bus.cpu_stall = bus.cpu_req & ~idle_hit;
  assign bus.cpu_dout  = idle_hit ? data_arr[req_idx][req_off] : 32'h0;
  assign cache_state   = state;

  // Next-state and next RAM-bus values; the bus is registered so cs rises in
  // the first cycle of WB/FILL. In IDLE the request address is used directly
  // because the latched copy is only written at the same edge.
  always_comb begin
    state_d = state;
    k_d     = k;
    cs_d    = bus.mem_cs;
    we_d    = bus.mem_we;
    addr_d  = bus.mem_addr;
    din_d   = bus.mem_din;
    case (state)
      IDLE: begin
        if (miss) begin
          k_d  = 2'd0;
          cs_d = 1'b1;
          if (valid[req_idx] & dirty[req_idx]) begin
            state_d = WB;
            we_d    = 1'b1;
            addr_d  = {tag_arr[req_idx], req_idx, 4'b0000};
            din_d   = data_arr[req_idx][0];
          end else begin
            state_d = FILL;
            we_d    = 1'b0;
            addr_d  = {req_tag, req_idx, 4'b0000};
          end
        end
      end
      WB: begin
        if (ack) begin
          state_d = WB_GAP;
          cs_d    = 1'b0;
        end
      end
      WB_GAP: begin
        cs_d = 1'b1;
        if (k == 2'd3) begin
          k_d     = 2'd0;
          state_d = FILL;
          we_d    = 1'b0;
          addr_d  = {lat_tag, lat_idx, 4'b0000};
        end else begin
          k_d     = k_nx;
          state_d = WB;
          we_d    = 1'b1;
          addr_d  = {tag_arr[lat_idx], lat_idx, k_nx, 2'b00};
          din_d   = data_arr[lat_idx][k_nx];
        end
      end
      FILL: begin
        if (ack) begin
          cs_d    = 1'b0;
          state_d = (k == 2'd3) ? IDLE : FILL_GAP;
        end
      end
      FILL_GAP: begin
        k_d     = k_nx;
        state_d = FILL;
        cs_d    = 1'b1;
        addr_d  = {lat_tag, lat_idx, k_nx, 2'b00};
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
      end
    endcase
  end

  // FSM, word counter, latched miss address and registered RAM bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k            <= 2'd0;
      lat_tag      <= '0;
      lat_idx      <= '0;
      bus.mem_cs   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= 32'h0;
      bus.mem_din  <= 32'h0;
    end else begin
      state        <= state_d;
      k            <= k_d;
      bus.mem_cs   <= cs_d;
      bus.mem_we   <= we_d;
      bus.mem_addr <= addr_d;
      bus.mem_din  <= din_d;
      if (miss) begin
        lat_tag <= req_tag;
        lat_idx <= req_idx;
      end
    end
  end

  // Line status: stores dirty a line, a finished writeback cleans it,
  // the last fill word validates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (idle_hit & bus.cpu_we) dirty[req_idx] <= 1'b1;
      if ((state == WB_GAP) && (k == 2'd3)) dirty[lat_idx] <= 1'b0;
      if ((state == FILL) && ack && (k == 2'd3)) begin
        valid[lat_idx] <= 1'b1;
        dirty[lat_idx] <= 1'b0;
      end
    end
  end

  // Tag and data storage, deliberately not reset (valid bits guard them).
  always_ff @(posedge clk) begin
    if (idle_hit & bus.cpu_we) data_arr[req_idx][req_off] <= bus.cpu_din;
    if ((state == FILL) && ack) data_arr[lat_idx][k] <= bus.mem_dout;
    if ((state == FILL) && ack && (k == 2'd3)) tag_arr[lat_idx] <= lat_tag;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a table of CPU accesses with expected stall counts and
// load data, a RAM model acking in the 4th cs cycle, and a scoreboard of
// expected RAM transactions popped as the RAM completes them.
module tb_dcache_ctrl;
  localparam logic [31:0] NONE   = 32'hFFFF_FFFF;
  localparam int          BUDGET = 200;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    int          exp_stall;
    logic        chk_dout;
    logic [31:0] exp_dout;
    logic [31:0] wb_base;
    logic [31:0] fill_base;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cache_state;

  dcache_if bus();

  dcache_ctrl #(.INDEX_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cache_state(cache_state)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  txn_t        exp_q[$];
  txn_t        t;
  logic [31:0] ram  [0:1023];
  logic [31:0] gold [0:1023];
  bit          ram_loaded;
  bit          gap_chk;
  logic [1:0]  cnt = 2'd0;

  function automatic logic [31:0] init_word(int i);
    return (i == 16) ? 32'hA5A5_A5A5 : {16'hC0DE, i[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model: acks in the 4th cycle of mem_cs, data read combinationally.
  assign bus.mem_ack  = bus.mem_cs && (cnt == 2'd3);
  assign bus.mem_dout = ram[bus.mem_addr[11:2]];

  // RAM timing, write storage and scoreboard pop on every completed transaction.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end
    if (bus.mem_cs) begin
      if (cnt == 2'd3) begin
        cnt     <= 2'd0;
        gap_chk = 1'b1;
        if (bus.mem_we) ram[bus.mem_addr[11:2]] <= bus.mem_din;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_txn: got we=%0d addr=%h expected none", bus.mem_we, bus.mem_addr);
        end else begin
          t = exp_q.pop_front();
          check("txn_we", {31'b0, bus.mem_we}, {31'b0, t.we});
          check("txn_addr", bus.mem_addr, t.addr);
          if (t.we) check("txn_wdata", bus.mem_din, t.data);
        end
      end else begin
        cnt <= cnt + 2'd1;
      end
    end else begin
      cnt <= 2'd0;
    end
  end

  // The RAM must see cs low in the cycle after every ack.
  always @(negedge clk) begin
    if (gap_chk) begin
      gap_chk = 1'b0;
      check("cs_gap", {31'b0, bus.mem_cs}, 32'h0);
    end
  end

  task automatic run_vec(input string name, input vec_t v);
    int n;
    bit zc;
    if (v.wb_base != NONE)
      for (int w = 0; w < 4; w++)
        exp_q.push_back('{1'b1, v.wb_base + 32'(4 * w), gold[(v.wb_base >> 2) + 32'(w)]});
    if (v.fill_base != NONE)
      for (int w = 0; w < 4; w++)
        exp_q.push_back('{1'b0, v.fill_base + 32'(4 * w), 32'h0});
    if (v.we) gold[v.addr[11:2]] = v.din;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = v.we;
    bus.cpu_addr = v.addr;
    bus.cpu_din  = v.din;
    #1;
    n  = 0;
    zc = 1'b0;
    while (bus.cpu_stall && n < BUDGET) begin
      if (!zc) begin
        check({name, "_dout_stalled"}, bus.cpu_dout, 32'h0);
        zc = 1'b1;
      end
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_stall_cycles"}, n, v.exp_stall);
    if (v.chk_dout) check({name, "_load_data"}, bus.cpu_dout, v.exp_dout);
    @(posedge clk);
    #1;
    check({name, "_sb_drained"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    vec_t vt [8];
    vec_t v;
    int   n;

    vt[0] = '{1'b0, 32'h040, 32'h0,         20, 1'b1, 32'hA5A5_A5A5, NONE,    32'h040};
    vt[1] = '{1'b0, 32'h044, 32'h0,          0, 1'b1, 32'hC0DE_0011, NONE,    NONE};
    vt[2] = '{1'b1, 32'h048, 32'hDEAD_BEEF,  0, 1'b0, 32'h0,         NONE,    NONE};
    vt[3] = '{1'b0, 32'h448, 32'h0,         40, 1'b1, 32'hC0DE_0112, 32'h040, 32'h440};
    vt[4] = '{1'b1, 32'h080, 32'h1234_5678, 20, 1'b0, 32'h0,         NONE,    32'h080};
    vt[5] = '{1'b0, 32'h080, 32'h0,          0, 1'b1, 32'h1234_5678, NONE,    NONE};
    vt[6] = '{1'b0, 32'h040, 32'h0,         20, 1'b1, 32'hA5A5_A5A5, NONE,    32'h040};
    vt[7] = '{1'b0, 32'h048, 32'h0,          0, 1'b1, 32'hDEAD_BEEF, NONE,    NONE};

    for (int i = 0; i < 1024; i++) gold[i] = init_word(i);
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0;
    bus.cpu_din  = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_state", {29'b0, cache_state}, 32'h0);
    check("reset_mem_cs", {31'b0, bus.mem_cs}, 32'h0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    check("reset_mem_din", bus.mem_din, 32'h0);
    check("reset_stall", {31'b0, bus.cpu_stall}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Reset during the second fill word: cs and state fall without a clock.
    exp_q.push_back('{1'b0, 32'h100, 32'h0});
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h100;
    n = 0;
    while (!(bus.mem_cs && bus.mem_addr == 32'h104) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("rst_fill2_reached", bus.mem_addr, 32'h104);
    #2 rst = 1'b1;
    #1;
    check("rst_async_cs", {31'b0, bus.mem_cs}, 32'h0);
    check("rst_async_state", {29'b0, cache_state}, 32'h0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_sb_drained", exp_q.size(), 32'h0);
    v = '{1'b0, 32'h100, 32'h0, 20, 1'b1, 32'hC0DE_0040, NONE, 32'h100};
    run_vec("post_rst_reload", v);
    // The dirty store to 0x80 was discarded by the reset.
    v = '{1'b0, 32'h080, 32'h0, 20, 1'b1, 32'hC0DE_0020, NONE, 32'h080};
    run_vec("post_rst_dirty_lost", v);
    v = '{1'b1, 32'h104, 32'hCAFE_F00D, 0, 1'b0, 32'h0, NONE, NONE};
    run_vec("dirty_idx0", v);

    // Drop cpu_req during the writeback: all 8 transactions must still finish.
    for (int w = 0; w < 4; w++)
      exp_q.push_back('{1'b1, 32'h100 + 32'(4 * w), gold[32'h40 + 32'(w)]});
    for (int w = 0; w < 4; w++)
      exp_q.push_back('{1'b0, 32'h500 + 32'(4 * w), 32'h0});
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h504;
    n = 0;
    while (!bus.mem_ack && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("drop_first_ack", {31'b0, bus.mem_ack}, 32'h1);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    check("drop_in_wb_gap", {29'b0, cache_state}, 32'h2);
    n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("drop_sb_drained", exp_q.size(), 32'h0);
    @(negedge clk);
    check("drop_end_idle", {29'b0, cache_state}, 32'h0);
    check("drop_end_stall", {31'b0, bus.cpu_stall}, 32'h0);
    v = '{1'b0, 32'h504, 32'h0, 0, 1'b1, 32'hC0DE_0141, NONE, NONE};
    run_vec("drop_line_filled", v);

    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU memory stage and the slow word-wide data RAM.
- Initiator side of the RAM's cs/we/addr/din/dout/ack handshake: it issues single-word transactions to fill and evict 4-word lines.
- Hits complete combinationally with no stall. Misses stall the CPU until the line has been written back (if dirty) and refilled.

Parameters:
INDEX_WIDTH, 4, log2 of line count (16 lines); tag = addr[31:INDEX_WIDTH+4], index = addr[INDEX_WIDTH+3:4], word offset = addr[3:2]
LINE_WORDS, 4, words per line; fixed, not overridable

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; addr/we/din held stable while cpu_stall=1
cpu_we  in  1  1=store word, 0=load word
cpu_addr  in  32  byte address; bits [1:0] ignored
cpu_din  in  32  store data
cpu_dout  out  32  load data, valid when cpu_req & ~cpu_we & ~cpu_stall
cpu_stall  out  1  1 while the current request cannot complete this cycle
mem_cs  out  1  RAM chip select, registered
mem_we  out  1  RAM write enable, registered, stable while mem_cs=1
mem_addr  out  32  RAM word-aligned byte address, registered
mem_din  out  32  write data to RAM, registered
mem_dout  in  32  RAM read data, valid in the mem_ack cycle
mem_ack  in  1  RAM completion pulse, one cycle
cache_state  out  3  current FSM state, for debug

Behaviour:
- Storage:
  - Per line: valid, dirty, tag, 4x32 data.
  - rst clears all valid/dirty bits, FSM->IDLE, mem_cs/mem_we=0, mem_addr/mem_din=0.
  - The data and tag arrays are not reset.
- Hit:
  - In IDLE, hit = cpu_req & valid[idx] & tag[idx]==req_tag, evaluated combinationally.
  - Load hit: cpu_dout = line word[offset] in the same cycle; cpu_stall=0.
  - Store hit: the word is written and dirty[idx]=1 at the clock edge; cpu_stall=0.
  - cpu_stall = cpu_req & ~(state==IDLE & hit).
  - cpu_dout = 0 whenever cpu_stall=1 or cpu_req=0.
- States (encoded 0..4): IDLE, WB, WB_GAP, FILL, FILL_GAP.
- IDLE, on cpu_req & miss:
  - If valid & dirty -> WB with k=0.
  - Else -> FILL with k=0.
  - mem_cs rises in the first cycle of the new state.
- WB:
  - mem_cs=1, mem_we=1, mem_addr={old_tag,idx,k,2'b00}, mem_din=word k.
  - Hold all outputs until mem_ack; at the ack edge -> WB_GAP with mem_cs=0.
- WB_GAP:
  - One cycle, mem_cs=0 (the RAM needs cs low to restart its sequence).
  - If k==3: clear dirty, k=0 -> FILL; else k+1 -> WB.
- FILL:
  - mem_cs=1, mem_we=0, mem_addr={req_tag,idx,k,2'b00}.
  - At the mem_ack edge: word k <= mem_dout.
  - If k==3: write tag, set valid=1, dirty=0 -> IDLE. Else -> FILL_GAP.
- FILL_GAP: one cycle, mem_cs=0, k+1 -> FILL.
- Return to IDLE: the next cycle re-evaluates as a hit, which completes the request (a store then merges and sets dirty).
- Handshake rules:
  - mem_cs is never high for two consecutive transactions without an intervening low cycle.
  - mem_ack while mem_cs=0 is ignored.
  - No timeout: a RAM that never acks stalls forever.
- Latency: with a RAM acking in the L-th cycle of mem_cs:
  - Clean miss stalls 4L+4 cycles.
  - Dirty miss stalls 8L+8 cycles.
  - For our RAM, L=4 gives 20 / 40 cycles.
- Edge cases:
  - cpu_req dropped mid-miss: the line operation still completes (never abort a RAM transaction), then IDLE.
  - Changes to cpu_addr mid-miss are not allowed; the miss uses the address latched at miss detection.
  - rst mid-miss drops mem_cs immediately and invalidates all lines; dirty data is lost by design.

Test Plan:
- Reset, load 0x40 with RAM word 0x10=0xA5A5A5A5 (L=4) -> stall 20 cycles; reads at mem_addr 0x40,0x44,0x48,0x4C with a cs-low gap between each; cpu_dout=0xA5A5A5A5 in cycle 20.
- Load 0x44 directly after -> stall=0 same cycle, no mem_cs activity, dout = RAM word 0x11.
- Store 0x48<-0xDEADBEEF, then load 0x448 (same index 4, different tag) -> stall 40 cycles; first 4 transactions are writes to 0x40..0x4C with 0xDEADBEEF at 0x48, then 4 reads 0x440..0x44C.
- Store miss to clean line 0x80 <-0x12345678 -> fill 0x80..0x8C, then store completes; reload 0x80 returns 0x12345678 with no stall.
- Assert rst in the 2nd FILL word (mem_cs=1) -> mem_cs=0 and state=0 asynchronously; a subsequent load of the same address misses again.
- Drop cpu_req during WB -> all 8 transactions still complete, FSM ends in IDLE, cpu_stall=0.
